leitor_display_sete_segmentos: RTL and testbench
================================================

// Module: leitor_display_sete_segmentos
// PURPOSE
//  Receive side of the seven-segment display interface: samples a multiplexed display bus
//  (segment lines + one-hot digit select), waits for a stable pattern, decodes it back to BCD.
//  Keeps the last value of every digit and emits a valid/ready event for each digit that changes.
//  Used as a loopback monitor of the PWM generator display path and as a panel reader.
// PARAMETERS
//  N_DIGITOS       4   number of multiplexed digits (1..8)
//  ESTAVEL_CICLOS  8   consecutive identical samples required before capture (2..255)
// PORTS
//  clock           in   1              single clock domain
//  reset_n         in   1              asynchronous, active-low reset
//  segmentos       in   7              segment lines a..g = bit6..bit0, active-high, asynchronous source
//  digito_sel      in   N_DIGITOS      digit select, one-hot when valid, asynchronous source
//  digitos         out  4*N_DIGITOS    last BCD per digit, digit i at [4i+3:4i]
//  erro_mask       out  N_DIGITOS      1 = last capture of digit i was not a valid 0..9 pattern
//  evento_valido   out  1              change event pending
//  evento_pronto   in   1              consumer accepts event when high together with evento_valido
//  evento_indice   out  3              digit index of pending event
//  evento_bcd      out  4              BCD of pending event (4'hF when erroneous)
//  sobrecarga      out  1              sticky: an event was lost
// BEHAVIOUR
//  Reset: digitos=0, erro_mask=0, evento_valido=0, evento_indice=0, evento_bcd=0, sobrecarga=0, FSM=OCIOSO.
//  Input path: segmentos and digito_sel each pass through a 2-FF synchronizer. All later logic uses the synchronized copies.
//  Decode table: 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
//   Any other pattern -> bcd 4'hF, erro=1.
//   Pattern 30 always decodes to 1; the driver's error glyph cannot be told apart from 1.
//  FSM states: OCIOSO, ESTABILIZANDO, CAPTURA.
//   OCIOSO: select one-hot -> ESTABILIZANDO with cnt=1. Select not one-hot -> stay.
//   ESTABILIZANDO: select or segments differ from the previous synchronized sample -> cnt=1.
//    Select not one-hot -> OCIOSO. Otherwise cnt++. cnt==ESTAVEL_CICLOS -> CAPTURA.
//   CAPTURA: one cycle. Writes digitos[idx] and erro_mask[idx].
//    Then -> ESPERA_TROCA (sub-flag of OCIOSO): no new capture until the select value changes.
//  Latency: a stable input reaches digitos 2+ESTAVEL_CICLOS+1 clocks after its first sampled edge.
//  Event generation (1-entry buffer) happens only in CAPTURA, and only if the new bcd/erro differs from the stored value.
//   Accept (valido&&pronto) and new event in the same cycle -> buffer reloaded, valido stays 1, no loss.
//   Buffer full, no accept, new event -> new event dropped, sobrecarga<=1 (cleared only by reset).
//   digitos is still updated.
//   evento_* fields are held stable while valido=1 and pronto=0.
//  Boundaries: select all-zero (blanking) or multi-hot -> no capture, stored values untouched.
//   N_DIGITOS=1 -> index always 0.
//  Reset mid-operation: all state cleared immediately. A pending event is discarded.
// CONFIGURATION
//  LEITOR_DISPLAY_PONTO_EN defined: adds input ponto (1b, decimal point, synchronized and checked for stability like segmentos).
//   Adds output pontos [N_DIGITOS-1:0], reset 0, captured per digit.
//   A change in the point alone also raises an event.
//  Undefined: no ponto/pontos ports; the point is neither observed nor stored.
// STRUCTURE
//  Package leitor_display_pkg holds:
//   - the ten segment-pattern constants, shared with the BCD->7seg decoder;
//   - BCD_ERRO = 4'hF;
//   - the FSM state enum;
//   - a clog2 helper for index width.
//  Sub-module codificador_sete_segmentos_para_bcd: combinational pattern -> {bcd, erro}, instantiated once.
//  Top: synchronizers, stability counter, FSM, digit register file, event buffer.
// TESTING
//  1. Reset, then hold sel=0001, seg=7'h6D for 12 clocks -> digitos[3:0]=2, one event (idx0,bcd2), sobrecarga=0.
//  2. Scan sel 0001/0010/0100/1000 with 7E/30/79/7B, 20 clocks each, pronto=1 -> digitos=16'h9310.
//     Four events; a second scan with identical data gives zero events.
//  3. seg=7'h01 on digit 2 -> digitos[11:8]=F, erro_mask[2]=1, event bcd=F.
//     Then 7'h5F -> bcd 6, erro_mask[2]=0.
//  4. Glitch: the pattern toggles every 5 clocks (< ESTAVEL_CICLOS) -> no capture, no event.
//     sel=0011 for 30 clocks -> no capture.
//  5. pronto=0, three digit changes -> first event held stable, sobrecarga=1.
//     Then pronto=1 -> that event accepted, valido drops.
//  6. Assert reset_n low mid-ESTABILIZANDO with an event pending -> all outputs 0 next edge, no event after release.

Source files
------------

// File: rtl/leitor_display_sete_segmentos_pkg.sv
// Shared constants for the seven-segment display path: segment glyphs (a..g = bit6..bit0),
// error BCD code, reader FSM states and an index-width helper.
package leitor_display_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    localparam logic [3:0] BCD_ERRO = 4'hF;

    typedef enum logic [1:0] {OCIOSO, ESTABILIZANDO, CAPTURA} estado_t;

    // Width needed to index v items, never less than one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/leitor_display_sete_segmentos_if.sv
// Change-event handshake of the display reader: producer drives valido/indice/bcd,
// consumer drives pronto.
interface leitor_display_sete_segmentos_if;
    logic       evento_valido;
    logic       evento_pronto;
    logic [2:0] evento_indice;
    logic [3:0] evento_bcd;

    modport master (output evento_valido, evento_indice, evento_bcd, input evento_pronto);
    modport slave  (input evento_valido, evento_indice, evento_bcd, output evento_pronto);
endinterface

// File: rtl/leitor_display_sete_segmentos_codificador.sv
// Combinational seven-segment glyph -> BCD decoder; unknown glyphs give BCD_ERRO with erro=1.
module codificador_sete_segmentos_para_bcd
    import leitor_display_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       erro
);
    always_comb begin
        bcd  = BCD_ERRO;
        erro = 1'b1;
        case (seg)
            SEG_0: begin bcd = 4'd0; erro = 1'b0; end
            SEG_1: begin bcd = 4'd1; erro = 1'b0; end
            SEG_2: begin bcd = 4'd2; erro = 1'b0; end
            SEG_3: begin bcd = 4'd3; erro = 1'b0; end
            SEG_4: begin bcd = 4'd4; erro = 1'b0; end
            SEG_5: begin bcd = 4'd5; erro = 1'b0; end
            SEG_6: begin bcd = 4'd6; erro = 1'b0; end
            SEG_7: begin bcd = 4'd7; erro = 1'b0; end
            SEG_8: begin bcd = 4'd8; erro = 1'b0; end
            SEG_9: begin bcd = 4'd9; erro = 1'b0; end
            default: ;
        endcase
    end
endmodule

// File: rtl/leitor_display_sete_segmentos.sv
// Multiplexed seven-segment bus reader: synchronize, wait for a stable one-hot pattern, decode,
// store per digit and emit one change event. LEITOR_DISPLAY_PONTO_EN adds the decimal point.
module leitor_display_sete_segmentos
    import leitor_display_pkg::*;
#(
    parameter int N_DIGITOS      = 4,
    parameter int ESTAVEL_CICLOS = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [6:0]             segmentos,
    input  logic [N_DIGITOS-1:0]   digito_sel,
`ifdef LEITOR_DISPLAY_PONTO_EN
    input  logic                   ponto,
    output logic [N_DIGITOS-1:0]   pontos,
`endif
    output logic [4*N_DIGITOS-1:0] digitos,
    output logic [N_DIGITOS-1:0]   erro_mask,
    output logic                   sobrecarga,
    leitor_display_sete_segmentos_if.master ev
);
    localparam int IW = clog2_min1(N_DIGITOS);

    logic [6:0]                seg_s1, seg_s2, seg_p;
    logic [N_DIGITOS-1:0]      sel_s1, sel_s2, sel_p, sel_cap;
    estado_t                   estado;
    logic [7:0]                cnt;
    logic                      espera;
    logic [N_DIGITOS-1:0][3:0] dig_q;
    logic [N_DIGITOS-1:0]      err_q;
    logic [3:0]                dec_bcd;
    logic                      dec_erro;
    logic [IW-1:0]             idx;
    logic                      mudou, diferente, aceita;

    function automatic logic um_quente(input logic [N_DIGITOS-1:0] s);
        return (s != '0) && ((s & (s - 1'b1)) == '0);
    endfunction

    function automatic logic [IW-1:0] indice_de(input logic [N_DIGITOS-1:0] s);
        indice_de = '0;
        for (int i = 0; i < N_DIGITOS; i++)
            if (s[i]) indice_de = IW'(i);
    endfunction

    // seg_p/sel_p hold the sample already proven stable, so CAPTURA decodes from them.
    codificador_sete_segmentos_para_bcd u_dec (.seg(seg_p), .bcd(dec_bcd), .erro(dec_erro));

    assign idx    = indice_de(sel_p);
    assign aceita = ev.evento_valido && ev.evento_pronto;
    assign digitos   = dig_q;
    assign erro_mask = err_q;

`ifdef LEITOR_DISPLAY_PONTO_EN
    logic pt_s1, pt_s2, pt_p;
    logic [N_DIGITOS-1:0] pt_q;
    assign pontos    = pt_q;
    assign diferente = (seg_s2 != seg_p) || (sel_s2 != sel_p) || (pt_s2 != pt_p);
    assign mudou     = (dig_q[idx] != dec_bcd) || (err_q[idx] != dec_erro) || (pt_q[idx] != pt_p);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pt_s1 <= 1'b0; pt_s2 <= 1'b0; pt_p <= 1'b0; pt_q <= '0;
        end else begin
            pt_s1 <= ponto; pt_s2 <= pt_s1; pt_p <= pt_s2;
            if (estado == CAPTURA) pt_q[idx] <= pt_p;
        end
    end
`else
    assign diferente = (seg_s2 != seg_p) || (sel_s2 != sel_p);
    assign mudou     = (dig_q[idx] != dec_bcd) || (err_q[idx] != dec_erro);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1 <= '0; seg_s2 <= '0; seg_p <= '0;
            sel_s1 <= '0; sel_s2 <= '0; sel_p <= '0; sel_cap <= '0;
            estado <= OCIOSO;
            cnt    <= '0;
            espera <= 1'b0;
            dig_q  <= '0;
            err_q  <= '0;
            sobrecarga       <= 1'b0;
            ev.evento_valido <= 1'b0;
            ev.evento_indice <= '0;
            ev.evento_bcd    <= '0;
        end else begin
            seg_s1 <= segmentos;  seg_s2 <= seg_s1; seg_p <= seg_s2;
            sel_s1 <= digito_sel; sel_s2 <= sel_s1; sel_p <= sel_s2;
            if (aceita) ev.evento_valido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    // After a capture, the same select must go away before it is read again.
                    if (!(espera && sel_s2 == sel_cap)) begin
                        espera <= 1'b0;
                        if (um_quente(sel_s2)) begin
                            estado <= ESTABILIZANDO;
                            cnt    <= 8'd1;
                        end
                    end
                end
                ESTABILIZANDO: begin
                    if (!um_quente(sel_s2)) estado <= OCIOSO;
                    else if (diferente) cnt <= 8'd1;
                    else begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == 8'(ESTAVEL_CICLOS)) estado <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    dig_q[idx] <= dec_bcd;
                    err_q[idx] <= dec_erro;
                    estado     <= OCIOSO;
                    espera     <= 1'b1;
                    sel_cap    <= sel_p;
                    if (mudou) begin
                        if (!ev.evento_valido || aceita) begin
                            ev.evento_valido <= 1'b1;
                            ev.evento_indice <= 3'(idx);
                            ev.evento_bcd    <= dec_bcd;
                        end else begin
                            sobrecarga <= 1'b1;
                        end
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_leitor_display_sete_segmentos.sv
// Bench for the seven-segment reader: expected events go to a queue when driven and are
// compared by a monitor when the DUT hands them over.
module tb_leitor_display_sete_segmentos;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  segmentos = '0;
    logic [3:0]  digito_sel = '0;
    logic [15:0] digitos;
    logic [3:0]  erro_mask;
    logic        sobrecarga;
`ifdef LEITOR_DISPLAY_PONTO_EN
    logic        ponto = 1'b0;
    logic [3:0]  pontos;
`endif

    leitor_display_sete_segmentos_if ev();

    leitor_display_sete_segmentos #(.N_DIGITOS(4), .ESTAVEL_CICLOS(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .segmentos(segmentos), .digito_sel(digito_sel),
`ifdef LEITOR_DISPLAY_PONTO_EN
        .ponto(ponto), .pontos(pontos),
`endif
        .digitos(digitos), .erro_mask(erro_mask), .sobrecarga(sobrecarga),
        .ev(ev)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [2:0] idx; logic [3:0] bcd; } ev_t;
    ev_t fila[$];
    ev_t esp;
    int total = 0, bad = 0, n_ev = 0;
    logic [3:0] m_dig[4];
    logic       m_err[4];

    // Handshake completes at the next rising edge when both are high here.
    always @(negedge clock) begin
        if (reset_n && ev.evento_valido && ev.evento_pronto) begin
            n_ev++;
            total++;
            if (fila.size() == 0) begin
                bad++;
                $display("FAIL evento_extra got idx=%0d bcd=%h, expected no event", ev.evento_indice, ev.evento_bcd);
            end else begin
                esp = fila.pop_front();
                if ({ev.evento_indice, ev.evento_bcd} !== esp) begin
                    bad++;
                    $display("FAIL evento got idx=%0d bcd=%h, expected idx=%0d bcd=%h",
                             ev.evento_indice, ev.evento_bcd, esp.idx, esp.bcd);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
        digito_sel = s;
        segmentos  = g;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present one digit long enough to capture; queue an event when the stored value changes.
    task automatic cap(input int d, input logic [6:0] g, input logic [3:0] b, input logic e, input bit enfila);
        if ((m_dig[d] !== b || m_err[d] !== e) && enfila) fila.push_back({3'(d), b});
        m_dig[d] = b;
        m_err[d] = e;
        drive(4'(1 << d), g, 20);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_dig[i] = 4'd0; m_err[i] = 1'b0; end
    endtask

    task automatic test_reset();
        ev.evento_pronto = 1'b0;
        reset_n = 1'b0;
        drive(4'd0, 7'd0, 3);
        total += 6;
        if (digitos !== 16'h0)      begin bad++; $display("FAIL reset_digitos got %h expected 0", digitos); end
        if (erro_mask !== 4'h0)     begin bad++; $display("FAIL reset_erro got %h expected 0", erro_mask); end
        if (ev.evento_valido !== 1'b0) begin bad++; $display("FAIL reset_valido got %b expected 0", ev.evento_valido); end
        if (ev.evento_indice !== 3'd0) begin bad++; $display("FAIL reset_indice got %0d expected 0", ev.evento_indice); end
        if (ev.evento_bcd !== 4'd0) begin bad++; $display("FAIL reset_bcd got %h expected 0", ev.evento_bcd); end
        if (sobrecarga !== 1'b0)    begin bad++; $display("FAIL reset_sobrecarga got %b expected 0", sobrecarga); end
        reset_n = 1'b1;
        model_reset();
        drive(4'd0, 7'd0, 2);
    endtask

    task automatic test_single();
        int n0;
        n0 = n_ev;
        ev.evento_pronto = 1'b1;
        fila.push_back({3'd0, 4'd2});
        m_dig[0] = 4'd2;
        drive(4'b0001, 7'h6D, 10);
        total++;
        if (digitos[3:0] !== 4'd0) begin bad++; $display("FAIL latencia_cedo got %h expected 0", digitos[3:0]); end
        drive(4'b0001, 7'h6D, 2);
        total++;
        if (digitos[3:0] !== 4'd2) begin bad++; $display("FAIL single_digito got %h expected 2", digitos[3:0]); end
        drive(4'd0, 7'd0, 6);
        total += 2;
        if (n_ev - n0 !== 1)     begin bad++; $display("FAIL single_eventos got %0d expected 1", n_ev - n0); end
        if (sobrecarga !== 1'b0) begin bad++; $display("FAIL single_sobrecarga got %b expected 0", sobrecarga); end
    endtask

    task automatic test_scan();
        logic [6:0] pat[4] = '{7'h7E, 7'h30, 7'h79, 7'h7B};
        logic [3:0] val[4] = '{4'd0, 4'd1, 4'd3, 4'd9};
        for (int pass = 0; pass < 2; pass++) begin
            int n0;
            n0 = n_ev;
            for (int i = 0; i < 4; i++) cap(i, pat[i], val[i], 1'b0, 1'b1);
            drive(4'd0, 7'd0, 6);
            total += 2;
            if (digitos !== 16'h9310) begin bad++; $display("FAIL scan_digitos pass%0d got %h expected 9310", pass, digitos); end
            if (n_ev - n0 !== (pass == 0 ? 4 : 0)) begin
                bad++; $display("FAIL scan_eventos pass%0d got %0d expected %0d", pass, n_ev - n0, pass == 0 ? 4 : 0);
            end
        end
    endtask

    task automatic test_erro();
        cap(2, 7'h01, 4'hF, 1'b1, 1'b1);
        drive(4'd0, 7'd0, 6);
        total += 2;
        if (digitos[11:8] !== 4'hF) begin bad++; $display("FAIL erro_digito got %h expected F", digitos[11:8]); end
        if (erro_mask[2] !== 1'b1)  begin bad++; $display("FAIL erro_mask_set got %b expected 1", erro_mask[2]); end
        cap(2, 7'h5F, 4'd6, 1'b0, 1'b1);
        drive(4'd0, 7'd0, 6);
        total += 2;
        if (digitos[11:8] !== 4'd6) begin bad++; $display("FAIL erro_recupera got %h expected 6", digitos[11:8]); end
        if (erro_mask[2] !== 1'b0)  begin bad++; $display("FAIL erro_mask_clr got %b expected 0", erro_mask[2]); end
    endtask

    task automatic test_glitch();
        int n0;
        logic [15:0] d0;
        n0 = n_ev;
        d0 = digitos;
        for (int k = 0; k < 8; k++) drive(4'b1000, (k % 2) ? 7'h30 : 7'h7E, 5);
        drive(4'd0, 7'd0, 6);
        total += 2;
        if (digitos !== d0)  begin bad++; $display("FAIL glitch_digitos got %h expected %h", digitos, d0); end
        if (n_ev !== n0)     begin bad++; $display("FAIL glitch_eventos got %0d expected %0d", n_ev, n0); end
        drive(4'b0011, 7'h7E, 30);
        drive(4'd0, 7'd0, 6);
        total += 2;
        if (digitos !== d0)  begin bad++; $display("FAIL multihot_digitos got %h expected %h", digitos, d0); end
        if (n_ev !== n0)     begin bad++; $display("FAIL multihot_eventos got %0d expected %0d", n_ev, n0); end
    endtask

    task automatic test_overflow();
        ev.evento_pronto = 1'b0;
        cap(0, 7'h5B, 4'd5, 1'b0, 1'b1);
        total++;
        if ({ev.evento_valido, ev.evento_indice, ev.evento_bcd} !== {1'b1, 3'd0, 4'd5}) begin
            bad++; $display("FAIL ovf_primeiro got v=%b idx=%0d bcd=%h expected v=1 idx=0 bcd=5",
                            ev.evento_valido, ev.evento_indice, ev.evento_bcd);
        end
        cap(1, 7'h33, 4'd4, 1'b0, 1'b0);
        cap(2, 7'h70, 4'd7, 1'b0, 1'b0);
        drive(4'd0, 7'd0, 6);
        total += 3;
        if ({ev.evento_valido, ev.evento_indice, ev.evento_bcd} !== {1'b1, 3'd0, 4'd5}) begin
            bad++; $display("FAIL ovf_estavel got v=%b idx=%0d bcd=%h expected v=1 idx=0 bcd=5",
                            ev.evento_valido, ev.evento_indice, ev.evento_bcd);
        end
        if (sobrecarga !== 1'b1)   begin bad++; $display("FAIL ovf_sobrecarga got %b expected 1", sobrecarga); end
        if (digitos !== 16'h9745)  begin bad++; $display("FAIL ovf_digitos got %h expected 9745", digitos); end
        ev.evento_pronto = 1'b1;
        drive(4'd0, 7'd0, 3);
        total += 2;
        if (ev.evento_valido !== 1'b0) begin bad++; $display("FAIL ovf_aceite got valido=%b expected 0", ev.evento_valido); end
        if (fila.size() !== 0)         begin bad++; $display("FAIL ovf_fila got %0d pending expected 0", fila.size()); end
    endtask

    task automatic test_reset_mid();
        int n0;
        ev.evento_pronto = 1'b0;
        cap(0, 7'h7E, 4'd0, 1'b0, 1'b0);
        total++;
        if (ev.evento_valido !== 1'b1) begin bad++; $display("FAIL mid_pendente got %b expected 1", ev.evento_valido); end
        drive(4'b0010, 7'h6D, 6);
        reset_n = 1'b0;
        #1;
        total += 6;
        if (digitos !== 16'h0)         begin bad++; $display("FAIL mid_digitos got %h expected 0", digitos); end
        if (erro_mask !== 4'h0)        begin bad++; $display("FAIL mid_erro got %h expected 0", erro_mask); end
        if (ev.evento_valido !== 1'b0) begin bad++; $display("FAIL mid_valido got %b expected 0", ev.evento_valido); end
        if (ev.evento_indice !== 3'd0) begin bad++; $display("FAIL mid_indice got %0d expected 0", ev.evento_indice); end
        if (ev.evento_bcd !== 4'd0)    begin bad++; $display("FAIL mid_bcd got %h expected 0", ev.evento_bcd); end
        if (sobrecarga !== 1'b0)       begin bad++; $display("FAIL mid_sobrecarga got %b expected 0", sobrecarga); end
        drive(4'd0, 7'd0, 3);
        reset_n = 1'b1;
        model_reset();
        ev.evento_pronto = 1'b1;
        n0 = n_ev;
        drive(4'd0, 7'd0, 20);
        total += 3;
        if (n_ev !== n0)               begin bad++; $display("FAIL mid_sem_evento got %0d expected %0d", n_ev, n0); end
        if (ev.evento_valido !== 1'b0) begin bad++; $display("FAIL mid_valido_pos got %b expected 0", ev.evento_valido); end
        if (digitos !== 16'h0)         begin bad++; $display("FAIL mid_digitos_pos got %h expected 0", digitos); end
    endtask

    initial begin
        ev.evento_pronto = 1'b0;
        test_reset();
        test_single();
        test_scan();
        test_erro();
        test_glitch();
        test_overflow();
        test_reset_mid();
        total++;
        if (fila.size() !== 0) begin bad++; $display("FAIL fila_final got %0d pending expected 0", fila.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
